uart_line_monitor: RTL and testbench

//   Far-end serial receiver for the uart transmit line (uart_XMIT_dataH): oversamples the line,

---
 rtl/uart_line_pkg.sv | 24 ++
 rtl/uart_line_monitor_if.sv | 24 ++
 rtl/uart_line_fifo.sv | 59 +++++
 rtl/uart_line_monitor.sv | 155 +++++++++++++++
 tb/tb_uart_line_monitor.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/uart_line_pkg.sv
// Shared types and constants for the UART line monitor: receiver FSM states,
// frame data width and the half-bit sample point helper.
package uart_line_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rxState_t;

   localparam int DATA_BITS        = 8;
   localparam int CLKS_PER_BIT_DEF = 16;

   // Start-bit confirmation point, counted from the cycle after the falling edge is seen.
   localparam int HALF_BIT_DEF = CLKS_PER_BIT_DEF / 2 - 1;

   function automatic int halfBitPoint(input int clksPerBit);
      return clksPerBit / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_line_monitor_if.sv
// Consumer-side bundle of the line monitor: popped byte stream plus status flags.
interface uart_line_monitor_if #(
   parameter int FIFO_DEPTH = 4
);
   import uart_line_pkg::*;

   logic [DATA_BITS-1:0]        rx_data;
   logic                        rx_valid;
   logic                        rx_ready;
   logic                        frame_err;
   logic                        overflow;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   modport master (
      output rx_data, rx_valid, frame_err, overflow, fifo_count,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overflow, fifo_count,
      output rx_ready
   );

endinterface

// File: rtl/uart_line_fifo.sv
// Small synchronous FIFO for received bytes; head byte is held after the last pop
// so the output does not change while the queue is empty.
module uart_line_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_l,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        pushData,
   output logic [WIDTH-1:0]        headData,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr, rdPtr;
   logic [AW:0]      cnt;
   logic [WIDTH-1:0] lastOut;
   logic             doPush, doPop;

   assign empty  = (cnt == '0);
   assign full   = (cnt == (AW+1)'(DEPTH));
   assign doPop  = pop && !empty;
   // A full queue still accepts a push when the same cycle frees a slot.
   assign doPush = push && (!full || doPop);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_l) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         cnt     <= '0;
         lastOut <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop) begin
            rdPtr   <= rdPtr + AW'(1);
            lastOut <= mem[rdPtr];
         end
         case ({doPush, doPop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   assign headData = empty ? lastOut : mem[rdPtr];
   assign count    = cnt;

endmodule

// File: rtl/uart_line_monitor.sv
// Far-end 8N1 receiver for the uart transmit line with a byte FIFO and error flags.
// Define UART_LINE_MON_PARITY_EN to receive 8E1 frames instead.
//
// state     | meaning
// IDLE      | line high, waiting for a falling edge
// START     | confirming start bit at half-bit point
// DATA      | sampling 8 data bits, LSB first
// PARITY    | sampling even parity bit (parity build only)
// STOP      | sampling stop bit, push byte if frame good
// WAIT_HIGH | bad stop bit, waiting for line to return high
module uart_line_monitor
   import uart_line_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst_l,
   input  logic                rx_line,
   uart_line_monitor_if.master mon
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_PT  = CW'(halfBitPoint(CLKS_PER_BIT));
   localparam logic [CW-1:0] FULL_PT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rxState_t                    state, stateNext;
   logic                        rxSync1, rxs;
   logic [CW-1:0]               cycleCnt;
   logic [BW-1:0]               bitCnt;
   logic [DATA_BITS-1:0]        shiftReg;
   logic                        halfTick, bitTick, clearCnt;
   logic                        pushReq, frameErrNext, parityBad;
   logic                        frameErrQ, overflowQ;
   logic                        fifoFull, fifoEmpty;
   logic [$clog2(FIFO_DEPTH):0] fifoCount;
   logic [DATA_BITS-1:0]        headData;

   // Synchronizer presets high so reset never looks like a start bit.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_l) begin
         rxSync1 <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rxSync1 <= rx_line;
         rxs     <= rxSync1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_l) state <= IDLE;
      else            state <= stateNext;
   end

   assign halfTick = (cycleCnt == HALF_PT);
   assign bitTick  = (cycleCnt == FULL_PT);

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:      if (!rxs) stateNext = START;
         START:     if (halfTick) stateNext = rxs ? IDLE : DATA;
         DATA: begin
            if (bitTick && bitCnt == LAST_BIT) begin
`ifdef UART_LINE_MON_PARITY_EN
               stateNext = PARITY;
`else
               stateNext = STOP;
`endif
            end
         end
         PARITY:    if (bitTick) stateNext = STOP;
         STOP:      if (bitTick) stateNext = rxs ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rxs) stateNext = IDLE;
         default:   stateNext = IDLE;
      endcase
   end

   always_comb begin
      clearCnt     = (stateNext != state) || (state == IDLE) || (state == DATA && bitTick);
      pushReq      = 1'b0;
      frameErrNext = 1'b0;
      case (state)
         PARITY: if (bitTick) frameErrNext = (^shiftReg) ^ rxs;
         STOP: begin
            // A parity failure already pulsed frame_err; keep it to one pulse per frame.
            if (bitTick) begin
               if (rxs) pushReq      = !parityBad;
               else     frameErrNext = !parityBad;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_l) begin
         cycleCnt <= '0;
         bitCnt   <= '0;
         shiftReg <= '0;
      end else begin
         cycleCnt <= clearCnt ? '0 : cycleCnt + 1'b1;
         if (state == IDLE) begin
            bitCnt <= '0;
         end else if (state == DATA && bitTick) begin
            bitCnt   <= bitCnt + 1'b1;
            shiftReg <= {rxs, shiftReg[DATA_BITS-1:1]};
         end
      end
   end

`ifdef UART_LINE_MON_PARITY_EN
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_l)                     parityBad <= 1'b0;
      else if (state == IDLE)             parityBad <= 1'b0;
      else if (state == PARITY && bitTick) parityBad <= frameErrNext;
   end
`else
   assign parityBad = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_l) begin
         frameErrQ <= 1'b0;
         overflowQ <= 1'b0;
      end else begin
         frameErrQ <= frameErrNext;
         if (pushReq && fifoFull && !mon.rx_ready) overflowQ <= 1'b1;
      end
   end

   uart_line_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_l (sys_rst_l),
      .push      (pushReq),
      .pop       (mon.rx_ready),
      .pushData  (shiftReg),
      .headData  (headData),
      .full      (fifoFull),
      .empty     (fifoEmpty),
      .count     (fifoCount)
   );

   assign mon.rx_data    = headData;
   assign mon.rx_valid   = !fifoEmpty;
   assign mon.frame_err  = frameErrQ;
   assign mon.overflow   = overflowQ;
   assign mon.fifo_count = fifoCount;

endmodule

// File: tb/tb_uart_line_monitor.sv
// Directed bench for uart_line_monitor: serial frames driven bit by bit, outputs
// checked against hand-computed values. Honours UART_LINE_MON_PARITY_EN.
module tb_uart_line_monitor;

   localparam int CLKS  = 16;
   localparam int DEPTH = 4;
`ifdef UART_LINE_MON_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   // Line fall to stop-bit sample: 3 cycles detect, half bit, then one bit per remaining bit.
   localparam int STOP_EDGE = 3 + CLKS / 2 + CLKS * (NBITS - 1);

   logic sysClk;
   logic sysRstL;
   logic rxLine;
   int   testsRun;
   int   testsFailed;
   int   validEdge;
   int   errCnt;

   uart_line_monitor_if #(.FIFO_DEPTH(DEPTH)) mon ();

   uart_line_monitor #(
      .CLKS_PER_BIT (CLKS),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .sys_clk   (sysClk),
      .sys_rst_l (sysRstL),
      .rx_line   (rxLine),
      .mon       (mon.master)
   );

   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic observe(input int idx, inout logic prevValid);
      if (mon.rx_valid && !prevValid && validEdge < 0) validEdge = idx;
      prevValid = mon.rx_valid;
      if (mon.frame_err) errCnt++;
   endtask

   task automatic holdLine(input logic level, input int cycles);
      logic prevValid;
      prevValid = mon.rx_valid;
      validEdge = -1;
      errCnt    = 0;
      rxLine    = level;
      for (int c = 0; c < cycles; c++) begin
         @(posedge sysClk); #1;
         observe(c + 1, prevValid);
      end
   endtask

   task automatic sendFrame(input logic [7:0] data, input logic stopBit, input logic parFlip,
                            input int tail, input int popEdge);
      logic [10:0] bits;
      logic        prevValid;
`ifdef UART_LINE_MON_PARITY_EN
      bits = {stopBit, (^data) ^ parFlip, data, 1'b0};
`else
      bits = {1'b1, stopBit, data, 1'b0};
      if (parFlip) bits[10] = 1'b1;
`endif
      prevValid = mon.rx_valid;
      validEdge = -1;
      errCnt    = 0;
      for (int c = 0; c < NBITS * CLKS + tail; c++) begin
         rxLine       = (c < NBITS * CLKS) ? bits[c / CLKS] : 1'b1;
         mon.rx_ready = (c + 1 == popEdge);
         @(posedge sysClk); #1;
         observe(c + 1, prevValid);
      end
      mon.rx_ready = 1'b0;
      rxLine       = 1'b1;
   endtask

   task automatic popByte(input string tag, input logic [7:0] expData);
      checkVal({tag, " valid"}, {31'd0, mon.rx_valid}, 32'd1);
      checkVal({tag, " data"}, {24'd0, mon.rx_data}, {24'd0, expData});
      mon.rx_ready = 1'b1;
      @(posedge sysClk); #1;
      mon.rx_ready = 1'b0;
   endtask

   task automatic checkCleared(input string tag);
      checkVal({tag, " data"},  {24'd0, mon.rx_data}, 32'd0);
      checkVal({tag, " valid"}, {31'd0, mon.rx_valid}, 32'd0);
      checkVal({tag, " count"}, 32'(mon.fifo_count), 32'd0);
      checkVal({tag, " ovf"},   {31'd0, mon.overflow}, 32'd0);
      checkVal({tag, " ferr"},  {31'd0, mon.frame_err}, 32'd0);
   endtask

   initial begin
      testsRun     = 0;
      testsFailed  = 0;
      sysRstL      = 1'b0;
      rxLine       = 1'b1;
      mon.rx_ready = 1'b0;
      repeat (3) @(posedge sysClk);
      #1;
      checkCleared("reset");
      sysRstL = 1'b1;
      holdLine(1'b1, 5);

      // Single good frame and its latency
      sendFrame(8'hA5, 1'b1, 1'b0, 4, 0);
      checkVal("t1 valid edge", 32'(validEdge), 32'(STOP_EDGE));
      checkVal("t1 count", 32'(mon.fifo_count), 32'd1);
      checkVal("t1 ferr", 32'(errCnt), 32'd0);
      popByte("t1 pop", 8'hA5);
      checkVal("t1 count after pop", 32'(mon.fifo_count), 32'd0);

      // Short low glitch is a false start
      holdLine(1'b0, 5);
      holdLine(1'b1, 40);
      checkVal("t2 ferr", 32'(errCnt), 32'd0);
      checkVal("t2 count", 32'(mon.fifo_count), 32'd0);
      checkVal("t2 valid edge", 32'(validEdge), 32'hFFFF_FFFF);

      // Bad stop bit, held break, then recovery
      sendFrame(8'h3C, 1'b0, 1'b0, 0, 0);
      checkVal("t3 ferr pulses", 32'(errCnt), 32'd1);
      checkVal("t3 count", 32'(mon.fifo_count), 32'd0);
      holdLine(1'b0, 40);
      checkVal("t3 break ferr", 32'(errCnt), 32'd0);
      holdLine(1'b1, 10);
      sendFrame(8'h81, 1'b1, 1'b0, 4, 0);
      checkVal("t3 next ferr", 32'(errCnt), 32'd0);
      checkVal("t3 next count", 32'(mon.fifo_count), 32'd1);
      popByte("t3 pop", 8'h81);

      // Overflow with consumer stalled
      for (int i = 1; i <= 4; i++) sendFrame(8'(i), 1'b1, 1'b0, 4, 0);
      checkVal("t4 count full", 32'(mon.fifo_count), 32'd4);
      checkVal("t4 ovf before", {31'd0, mon.overflow}, 32'd0);
      sendFrame(8'h05, 1'b1, 1'b0, 4, 0);
      checkVal("t4 count after drop", 32'(mon.fifo_count), 32'd4);
      checkVal("t4 ovf set", {31'd0, mon.overflow}, 32'd1);
      checkVal("t4 ferr", 32'(errCnt), 32'd0);
      for (int i = 1; i <= 4; i++) popByte("t4 pop", 8'(i));
      checkVal("t4 ovf sticky", {31'd0, mon.overflow}, 32'd1);
      checkVal("t4 empty valid", {31'd0, mon.rx_valid}, 32'd0);
      checkVal("t4 data held", {24'd0, mon.rx_data}, 32'h04);
      mon.rx_ready = 1'b1;
      @(posedge sysClk); #1;
      mon.rx_ready = 1'b0;
      checkVal("t4 pop on empty", 32'(mon.fifo_count), 32'd0);

      // Full FIFO with push and pop on the same edge
      sysRstL = 1'b0;
      @(posedge sysClk); #1;
      sysRstL = 1'b1;
      checkVal("t5 ovf cleared", {31'd0, mon.overflow}, 32'd0);
      for (int i = 0; i < 4; i++) sendFrame(8'h10 + 8'(i), 1'b1, 1'b0, 4, 0);
      sendFrame(8'h77, 1'b1, 1'b0, 4, STOP_EDGE);
      checkVal("t5 count", 32'(mon.fifo_count), 32'd4);
      checkVal("t5 ovf", {31'd0, mon.overflow}, 32'd0);
      popByte("t5 pop1", 8'h11);
      popByte("t5 pop2", 8'h12);
      popByte("t5 pop3", 8'h13);
      popByte("t5 pop4", 8'h77);
      checkVal("t5 count end", 32'(mon.fifo_count), 32'd0);

      // Reset mid-frame, then a clean frame
      holdLine(1'b0, CLKS);
      holdLine(1'b1, 44);
      sysRstL = 1'b0;
      @(posedge sysClk); #1;
      checkCleared("t6 reset");
      sysRstL = 1'b1;
      holdLine(1'b1, 20);
      checkVal("t6 idle count", 32'(mon.fifo_count), 32'd0);
`ifdef UART_LINE_MON_PARITY_EN
      sendFrame(8'h42, 1'b1, 1'b1, 4, 0);
      checkVal("t6 parity ferr", 32'(errCnt), 32'd1);
      checkVal("t6 parity count", 32'(mon.fifo_count), 32'd0);
`else
      sendFrame(8'h42, 1'b1, 1'b0, 4, 0);
      checkVal("t6 ferr", 32'(errCnt), 32'd0);
      checkVal("t6 count", 32'(mon.fifo_count), 32'd1);
      popByte("t6 pop", 8'h42);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
